// File: rtl/seq_sign_mul_if.sv
// seq_sign_mul_if: operand/product handshake bundle for seq_sign_mul.
//   N         : operand width in bits (product is 2N bits)
//   in_valid  : producer presents a and b
//   in_ready  : multiplier can accept operands
//   a, b      : two's complement multiplicand / multiplier
//   out_valid : out holds a finished product
//   out_ready : consumer accepts out
//   out       : two's complement product a*b
// Modports: master = producer/consumer side, slave = multiplier side.
interface seq_sign_mul_if #(
  parameter int unsigned N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/seq_sign_mul.sv
// seq_sign_mul: iterative radix-2 Booth signed multiplier, one multiplier
// bit per cycle.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : seq_sign_mul_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/out)
// IDLE accepts operands, BUSY runs N Booth steps, DONE holds the product
// until the consumer takes it. out keeps the last product while IDLE.
// Optional macro SEQ_SIGN_MUL_ZERO_BYPASS_EN: a zero operand finishes with
// out=0 one cycle after accept instead of N.
module seq_sign_mul #(
  parameter int unsigned N = 8
) (
  input logic          clk,
  input logic          rst,
  seq_sign_mul_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N:0]     acc_q,   acc_d;
  logic [N-1:0]   mq_q,    mq_d;
  logic           qm1_q,   qm1_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [2*N-1:0] out_q,   out_d;

  // Booth step datapath
  logic [N:0]     mcand_ext;
  logic [N:0]     sum;
  logic [N:0]     acc_sh;
  logic [N-1:0]   mq_sh;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;

  always_comb begin
    mcand_ext = {mcand_q[N-1], mcand_q};
    sum       = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   sum = acc_q + mcand_ext;
      2'b10:   sum = acc_q - mcand_ext;
      default: sum = acc_q;
    endcase
    // Arithmetic right shift of the {acc, multiplier} pair
    acc_sh = {sum[N], sum[N:1]};
    mq_sh  = {sum[0], mq_q[N-1:1]};
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = bus.a;
          mq_d    = bus.b;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(N);
          state_d = BUSY;
`ifdef SEQ_SIGN_MUL_ZERO_BYPASS_EN
          // Zero operand: a single step on all-zero operands yields out=0,
          // so out_valid rises one edge after accept.
          if ((bus.a == '0) || (bus.b == '0)) begin
            mcand_d = '0;
            mq_d    = '0;
            cnt_d   = CW'(1);
          end
`endif
        end
      end

      BUSY: begin
        acc_d = acc_sh;
        mq_d  = mq_sh;
        qm1_d = mq_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Exact product fits in 2N bits; acc MSB is only a guard bit.
          out_d   = {acc_sh[N-1:0], mq_sh};
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: doc/seq_sign_mul.md
SEQ_SIGN_MUL -- requirements
Module: seq_sign_mul

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operands a and b are presented.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  N  multiplicand, two's complement.
REQ-007 Port: b  input  N  multiplier, two's complement.
REQ-008 Port: out_valid  output  1  out holds a finished product.
REQ-009 Port: out_ready  input  1  consumer accepts out.
REQ-010 Port: out  output  2N  signed product a*b, two's complement.

Function
REQ-011 The block SHALL compute the exact 2N-bit signed product with iterative radix-2 Booth recoding, one multiplier bit per cycle.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept: the edge where in_valid=1 and in_ready=1 SHALL capture a and b, clear the accumulator, load the iteration counter with N, and enter BUSY.
REQ-015 a and b SHALL be ignored whenever no accept occurs; changes during BUSY SHALL NOT affect the result.
REQ-016 BUSY SHALL last exactly N cycles; out_valid SHALL rise N edges after the accepting edge, i.e. latency N cycles.
REQ-017 Each BUSY step SHALL add, subtract or skip the captured multiplicand per the Booth pair {b[i], b[i-1]} (b[-1]=0), then arithmetic-right-shift the {acc, multiplier} pair by one bit.
REQ-018 Operand -2^(N-1) on either or both inputs SHALL give the correct product; the internal accumulator SHALL be N+1 bits so that no overflow occurs.
REQ-019 DONE SHALL hold out and out_valid stable until out_valid=1 and out_ready=1 at an edge; that edge SHALL move to IDLE.
REQ-020 No back-to-back overlap: a new accept SHALL NOT occur before the edge after the output handshake.
REQ-021 out SHALL retain the last product after returning to IDLE, until the next product or reset.
REQ-022 out_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-023 When rst=1 at an edge, the FSM SHALL enter IDLE and out, accumulator, operand registers and counter SHALL clear to 0.
REQ-024 Reset values: in_ready=1, out_valid=0, out=0 in the cycle after reset.
REQ-025 Reset during BUSY or DONE SHALL abort the operation with no out_valid pulse; rst SHALL take priority over every handshake at the same edge.

Configuration
REQ-026 Macro SEQ_SIGN_MUL_ZERO_BYPASS_EN, when defined, SHALL add zero early termination: if the captured a or b is 0, the FSM SHALL go from accept directly to DONE with out=0, giving latency 1.
REQ-027 Without SEQ_SIGN_MUL_ZERO_BYPASS_EN every accepted operation, including a zero operand, SHALL take exactly N cycles; ports are identical in both builds.

Verification (N=8)
REQ-028 Reset then idle -> in_ready=1, out_valid=0, out=16'h0000.
REQ-029 a=8'h8A (-118), b=8'h16 (22) -> out=16'hF5DC (-2596), out_valid 8 cycles after accept.
REQ-030 Corner products: -128*-128 -> 16'h4000; -128*127 -> 16'hC080; 127*127 -> 16'h3F01; -1*-1 -> 16'h0001.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE, then 1 -> out stays stable, in_ready=0 throughout, IDLE on the handshake edge.
REQ-032 Reset pulse 3 cycles after accept -> no out_valid, out=0, next accept 3*5 -> 16'h000F.
REQ-033 a=0, b=-5 -> out=0; latency 1 with SEQ_SIGN_MUL_ZERO_BYPASS_EN, 8 without it.
